fraction_reduce: RTL



---
 rtl/fraction_reduce.sv | 117 +++++++++++
 1 files changed

// File: rtl/fraction_reduce.sv
// fraction_reduce: divides num and den by their gcd g with one shared restoring divider,
// numerator first, then denominator, and reports the fraction in lowest terms.
module fraction_reduce #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             read,
   input  logic [WIDTH-1:0] num,
   input  logic [WIDTH-1:0] den,
   input  logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] num_out,
   output logic [WIDTH-1:0] den_out,
   output logic             write,
   output logic             err,
   output logic             busy
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, DIV_NUM, DIV_DEN, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] d_q, d_d, g_q, g_d, div_q, div_d, rem_q, rem_d, qn_q, qn_d;
   logic [WIDTH-1:0] num_out_q, num_out_d, den_out_q, den_out_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic err_q, err_d;
   logic [WIDTH:0] trial, diff;
   logic ge;
   logic [WIDTH-1:0] div_step, rem_step;
   // remainder stays below g, so the restored value always fits back into WIDTH bits
   assign trial    = {rem_q, div_q[WIDTH-1]};
   assign diff     = trial - {1'b0, g_q};
   assign ge       = trial >= {1'b0, g_q};
   assign div_step = {div_q[WIDTH-2:0], ge};
   assign rem_step = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   always_comb begin
      state_d   = state_q;
      d_d       = d_q;
      g_d       = g_q;
      div_d     = div_q;
      rem_d     = rem_q;
      qn_d      = qn_q;
      cnt_d     = cnt_q;
      num_out_d = num_out_q;
      den_out_d = den_out_q;
      err_d     = err_q;
      case (state_q)
         IDLE: if (read) begin
            d_d = den;
            g_d = g;
            if (g == '0) begin
               num_out_d = num;
               den_out_d = den;
               err_d     = 1'b1;
               state_d   = DONE;
            end else begin
               div_d   = num;
               rem_d   = '0;
               cnt_d   = CW'(WIDTH - 1);
               state_d = DIV_NUM;
            end
         end
         DIV_NUM: begin
            div_d = div_step;
            rem_d = rem_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               qn_d    = div_step;
               div_d   = d_q;
               rem_d   = '0;
               cnt_d   = CW'(WIDTH - 1);
               state_d = DIV_DEN;
            end
         end
         DIV_DEN: begin
            div_d = div_step;
            rem_d = rem_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               num_out_d = qn_q;
               den_out_d = div_step;
               err_d     = 1'b0;
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= IDLE;
         d_q       <= '0;
         g_q       <= '0;
         div_q     <= '0;
         rem_q     <= '0;
         qn_q      <= '0;
         cnt_q     <= '0;
         num_out_q <= '0;
         den_out_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         d_q       <= d_d;
         g_q       <= g_d;
         div_q     <= div_d;
         rem_q     <= rem_d;
         qn_q      <= qn_d;
         cnt_q     <= cnt_d;
         num_out_q <= num_out_d;
         den_out_q <= den_out_d;
         err_q     <= err_d;
      end
   end
   assign num_out = num_out_q;
   assign den_out = den_out_q;
   assign err     = err_q;
   assign write   = state_q == DONE;
   assign busy    = state_q != IDLE;
endmodule
